// File: rtl/squash_io_adapter.sv
// squash_io_adapter: Caravel pad/Wishbone adapter for a generic game core.
// Synchronises and debounces the game input pads, registers the core outputs
// onto the output pad range, drives the core reset and exposes a small
// Wishbone register file (CTRL, SW_IN, DB_LIMIT, STATUS).

`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module squash_io_adapter #(
  parameter int                N_IN      = 4,
  parameter int                N_OUT     = 8,
  parameter int                IN_BASE   = 8,
  parameter int                OUT_BASE  = 12,
  parameter int                DB_W      = 16,
  parameter logic [DB_W-1:0]   DB_RESET  = 16'd1000,
  parameter logic [31:0]       BASE_ADDR = 32'h3000_0000
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  input  logic [`MPRJ_IO_PADS-1:0]  io_in,
  output logic [`MPRJ_IO_PADS-1:0]  io_out,
  output logic [`MPRJ_IO_PADS-1:0]  io_oeb,
  output logic [N_IN-1:0]           game_in,
  input  logic [N_OUT-1:0]          game_out,
  output logic                      game_reset
);

  localparam int PADS = `MPRJ_IO_PADS;

  // Register file state
  logic [2:0]       ctrl_q, ctrl_d;
  logic [N_IN-1:0]  sw_in_q, sw_in_d;
  logic [DB_W-1:0]  db_limit_q, db_limit_d;
  logic [N_OUT-1:0] out_q;
  logic             ack_q;
  logic [31:0]      dat_q, dat_d;
  logic             game_reset_q;

  // Debounced pad levels, one bit per game input
  logic [N_IN-1:0]  stable_vec;

  // Bus decode: one access per ack, so a held strobe is served every 2 cycles
  logic        wb_hit;
  logic        wb_req;
  logic        wb_wr;
  logic [1:0]  reg_sel;
  logic [31:0] be_mask;
  logic [31:0] rd_data;
  logic [31:0] wr_merged;
  logic [31:0] status_word;

  assign wb_hit  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wb_req  = wbs_cyc_i & wbs_stb_i & wb_hit & ~ack_q;
  assign wb_wr   = wb_req & wbs_we_i;
  assign reg_sel = wbs_adr_i[3:2];

  // Expand byte enables into a bit mask
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_be
      assign be_mask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
    end
  endgenerate

  assign status_word = 32'(out_q) | (32'(stable_vec) << 16);

  // Current value of the addressed register, zero-extended; unused bits read 0
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      2'd0: rd_data = 32'(ctrl_q);
      2'd1: rd_data = 32'(sw_in_q);
      2'd2: rd_data = 32'(db_limit_q);
      default: rd_data = status_word;
    endcase
  end

  // Byte-lane merge of write data into the current register contents
  assign wr_merged = (rd_data & ~be_mask) | (wbs_dat_i & be_mask);

  // Next-state for the writable registers; STATUS ignores writes
  always_comb begin
    ctrl_d     = ctrl_q;
    sw_in_d    = sw_in_q;
    db_limit_d = db_limit_q;
    dat_d      = '0;
    if (wb_req && !wbs_we_i) begin
      dat_d = rd_data;
    end
    if (wb_wr) begin
      case (reg_sel)
        2'd0: ctrl_d     = wr_merged[2:0];
        2'd1: sw_in_d    = wr_merged[N_IN-1:0];
        2'd2: db_limit_d = wr_merged[DB_W-1:0];
        default: ;
      endcase
    end
  end

  // Register file, bus handshake, output capture and core reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_q       <= 3'b001;
      sw_in_q      <= '0;
      db_limit_q   <= DB_RESET;
      out_q        <= '0;
      ack_q        <= 1'b0;
      dat_q        <= '0;
      game_reset_q <= 1'b1;
    end else begin
      ctrl_q       <= ctrl_d;
      sw_in_q      <= sw_in_d;
      db_limit_q   <= db_limit_d;
      out_q        <= game_out;
      ack_q        <= wb_req;
      dat_q        <= dat_d;
      game_reset_q <= ctrl_q[2];
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign game_reset = game_reset_q;

  // Per-input synchroniser and debouncer
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_in
      logic            s1_q;
      logic            s2_q;
      logic            stable_q;
      logic [DB_W-1:0] cnt_q;

      // A level must differ from stable for more than DB_LIMIT cycles to commit
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          s1_q     <= 1'b0;
          s2_q     <= 1'b0;
          stable_q <= 1'b0;
          cnt_q    <= '0;
        end else begin
          s1_q <= io_in[IN_BASE + gi];
          s2_q <= s1_q;
          if (s2_q == stable_q) begin
            cnt_q <= '0;
          end else if (cnt_q >= db_limit_q) begin
            stable_q <= s2_q;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end

      assign stable_vec[gi] = stable_q;
    end
  endgenerate

  // Source select only switches the mux; debouncers keep running either way
  assign game_in = ctrl_q[1] ? sw_in_q : stable_vec;

  // Pad drivers: only the output range is ever driven
  generate
    for (gi = 0; gi < PADS; gi++) begin : g_pad
      if ((gi >= OUT_BASE) && (gi < OUT_BASE + N_OUT)) begin : g_out
        assign io_out[gi] = ctrl_q[0] & out_q[gi - OUT_BASE];
        assign io_oeb[gi] = ~ctrl_q[0];
      end else begin : g_idle
        assign io_out[gi] = 1'b0;
        assign io_oeb[gi] = 1'b1;
      end
    end
  endgenerate

  // Inputs consumed only in part
  logic unused_bits;
  assign unused_bits = ^{io_in, wbs_adr_i[1:0], wr_merged};

endmodule

// File: tb/tb_squash_io_adapter.sv
// Directed testbench for squash_io_adapter with default parameters.

`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module tb_squash_io_adapter;

  localparam int PADS = `MPRJ_IO_PADS;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic              clk;
  logic              srst;
  logic              cyc, stb, we;
  logic [3:0]        sel;
  logic [31:0]       adr, wdat;
  logic              ack;
  logic [31:0]       rdat;
  logic [PADS-1:0]   io_in, io_out, io_oeb;
  logic [3:0]        game_in;
  logic [7:0]        game_out;
  logic              game_reset;

  int n_checks = 0;
  int n_pass   = 0;

  logic [PADS-1:0] oeb_on;
  logic [31:0]     rd;
  int              acks;

  squash_io_adapter dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (srst),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .game_in    (game_in),
    .game_out   (game_out),
    .game_reset (game_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s: got 0x%0h", tag, got);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One Wishbone access; called and returns on a falling edge
  task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
    logic got;
    got = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1'b1;
    end
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("wb_ack", 64'(got), 64'd1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb_access(a, 1'b1, d, s, r);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    wb_access(a, 1'b0, 32'h0, 4'hF, r);
  endtask

  initial begin
    srst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    io_in = '0; game_out = '0;
    oeb_on = '1;
    oeb_on[19:12] = '0;

    // Reset state
    step(3);
    check("rst_game_reset", 64'(game_reset), 64'd1);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_io_out", 64'(io_out), 64'd0);
    check("rst_io_oeb", 64'(io_oeb), 64'(oeb_on));
    srst = 1'b0;
    step(1);
    check("rel_game_reset", 64'(game_reset), 64'd0);

    wb_read(BASE + 32'h0, rd); check("rd_ctrl", 64'(rd), 64'h1);
    wb_read(BASE + 32'h4, rd); check("rd_sw_in", 64'(rd), 64'h0);
    wb_read(BASE + 32'h8, rd); check("rd_db_limit", 64'(rd), 64'd1000);
    wb_read(BASE + 32'hC, rd); check("rd_status", 64'(rd), 64'h0);

    // Debounce with DB_LIMIT=3: commit after edge n+5
    wb_write(BASE + 32'h8, 32'd3, 4'hF);
    wb_read(BASE + 32'h8, rd); check("rd_db_limit3", 64'(rd), 64'd3);
    io_in[8] = 1'b1;
    step(5);
    check("db_before_n5", 64'(game_in[0]), 64'd0);
    step(1);
    check("db_after_n5", 64'(game_in[0]), 64'd1);
    io_in[8] = 1'b0;
    step(10);
    check("db_fall", 64'(game_in[0]), 64'd0);

    // 3-cycle glitch never commits
    io_in[8] = 1'b1; step(3); io_in[8] = 1'b0;
    step(10);
    check("glitch3", 64'(game_in[0]), 64'd0);

    // 4-cycle pulse just commits
    io_in[8] = 1'b1; step(4); io_in[8] = 1'b0;
    step(2);
    check("pulse4_commit", 64'(game_in[0]), 64'd1);
    step(10);
    check("pulse4_release", 64'(game_in[0]), 64'd0);

    // Output path
    game_out = 8'hA5;
    step(1);
    check("io_out_a5", 64'(io_out[19:12]), 64'hA5);
    check("io_oeb_en", 64'(io_oeb), 64'(oeb_on));
    wb_write(BASE + 32'h0, 32'h0, 4'hF);
    check("io_out_dis", 64'(io_out), 64'd0);
    check("io_oeb_dis", 64'(io_oeb), 64'({PADS{1'b1}}));

    // Software inputs
    wb_write(BASE + 32'h0, 32'h3, 4'hF);
    wb_write(BASE + 32'h4, 32'h9, 4'hF);
    check("sw_game_in", 64'(game_in), 64'h9);
    io_in[8] = 1'b1;
    step(10);
    check("sw_game_in_pads", 64'(game_in), 64'h9);
    wb_read(BASE + 32'hC, rd); check("rd_status_live", 64'(rd), 64'h0001_00A5);

    // Byte-lane masking and STATUS write ignored
    wb_write(BASE + 32'h0, 32'h0, 4'b0010);
    wb_read(BASE + 32'h0, rd); check("ctrl_sel_mask", 64'(rd), 64'h3);
    wb_write(BASE + 32'hC, 32'h0, 4'hF);
    wb_read(BASE + 32'hC, rd); check("status_ro", 64'(rd), 64'h0001_00A5);

    // Out-of-window access
    acks = 0;
    cyc = 1; stb = 1; we = 1; adr = BASE + 32'h10; wdat = 32'h0; sel = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    cyc = 0; stb = 0; we = 0;
    check("oow_no_ack", 64'(acks), 64'd0);
    wb_read(BASE + 32'h0, rd); check("oow_ctrl", 64'(rd), 64'h3);

    // Soft reset: game_reset one cycle after ack
    wb_write(BASE + 32'h0, 32'h5, 4'hF);
    check("soft_rst_ack", 64'(game_reset), 64'd0);
    step(1);
    check("soft_rst_next", 64'(game_reset), 64'd1);
    wb_write(BASE + 32'h0, 32'h1, 4'hF);
    step(1);
    check("soft_rst_clr", 64'(game_reset), 64'd0);

    // Reset during a strobe
    acks = 0;
    cyc = 1; stb = 1; we = 1; adr = BASE; wdat = 32'h2; sel = 4'hF;
    srst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    cyc = 0; stb = 0; we = 0;
    check("rst_mid_no_ack", 64'(acks), 64'd0);
    srst = 1'b0;
    step(1);
    wb_read(BASE + 32'h0, rd); check("rst_mid_ctrl", 64'(rd), 64'h1);
    wb_read(BASE + 32'h8, rd); check("rst_mid_db", 64'(rd), 64'd1000);

    // DB_LIMIT lowered below an in-flight count commits on the next cycle
    step(20);
    check("db_inflight_hold", 64'(game_in[0]), 64'd0);
    wb_write(BASE + 32'h8, 32'd5, 4'hF);
    step(1);
    check("db_inflight_commit", 64'(game_in[0]), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/squash_io_adapter.md
# squash_io_adapter

Parametrised Caravel adapter between the user-project wrapper pads/Wishbone bus and a generic game core (solo_squash and successors). It synchronises and debounces N_IN pad inputs, registers N_OUT core outputs onto a configurable pad range, and generates the core reset. A small Wishbone register file lets the management SoC:
- enable or tristate the outputs,
- substitute software inputs for pad inputs,
- tune the debounce time,
- read back live status.

## Interface
Parameters:
- N_IN, 4: game inputs (1..16)
- N_OUT, 8: game outputs (1..16)
- IN_BASE, 8: first pad index for inputs
- OUT_BASE, 12: first pad index for outputs; input and output ranges must not overlap and must lie within `MPRJ_IO_PADS
- DB_W, 16: debounce counter width
- DB_RESET, 16'd1000: reset value of DB_LIMIT
- BASE_ADDR, 32'h3000_0000: Wishbone base address; 16-byte window

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset, synchronous, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone classic cycle, strobe, write
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- io_in  in  `MPRJ_IO_PADS  pad inputs
- io_out  out  `MPRJ_IO_PADS  pad outputs
- io_oeb  out  `MPRJ_IO_PADS  pad output enables, active-low
- game_in  out  N_IN  inputs to the core
- game_out  in  N_OUT  outputs from the core
- game_reset  out  1  core reset, active-high

## Operation
Registers (word offset; hit when adr[31:4]==BASE_ADDR[31:4]):
- 0x0 CTRL, reset 0x1:
  - bit0 EN: drive output pads
  - bit1 SRC: 0 = debounced pads, 1 = SW_IN
  - bit2 SOFT_RST: level-sensitive, cleared by software
- 0x4 SW_IN, reset 0: bits [N_IN-1:0]
- 0x8 DB_LIMIT, reset DB_RESET: bits [DB_W-1:0]
- 0xC STATUS, read-only: [N_OUT-1:0] = out_q, [16+N_IN-1:16] = debounced stable[]; writes ignored

Register access rules:
- Writes apply per byte lane under wbs_sel_i.
- Unused bits read 0 and are not writable.
- Accesses outside the window receive no ack and do not change any state.

Input path, per bit:
- Two-flop synchroniser s1 -> s2.
- Debouncer with counter cnt[DB_W-1:0] and register stable:
  - If s2==stable: cnt<=0.
  - Else if cnt>=DB_LIMIT: stable<=s2, cnt<=0.
  - Else: cnt<=cnt+1.
- A glitch that returns before the limit is reached resets the count and never reaches stable.
- game_in = SRC ? SW_IN : stable (mux of registered values).

Output path:
- out_q <= game_out every cycle.
- Output pads (OUT_BASE+i): io_out = EN ? out_q[i] : 0, io_oeb = ~EN.
- Input pads: io_out=0, io_oeb=1.
- All other pads: io_out=0, io_oeb=1.

Core reset: game_reset is a register, <= wb_rst_i | SOFT_RST.

Reset values:
- wbs_ack_o=0, wbs_dat_o=0, game_reset=1.
- out_q, s1, s2, stable, cnt all 0.
- Therefore io_out=0, output pads io_oeb=0, all other pads io_oeb=1.

## Timing
Wishbone:
- ack is registered. It rises the cycle after cyc&stb is seen with ack low and lasts exactly 1 cycle, so a held strobe gives at most one ack every 2 cycles.
- Write data takes effect on the ack edge.
- Read data is valid while ack is high.

Latencies:
- Pad sampled at edge n reaches s2 at edge n+1. With the level held, stable updates at edge n+2+DB_LIMIT. DB_LIMIT=0 gives 2-cycle latency.
- game_out to io_out: 1 cycle.
- SOFT_RST write to game_reset: 1 cycle after ack.
- CTRL.EN write: io_oeb changes the same cycle the register updates.

Boundary cases:
- DB_LIMIT written below an in-flight cnt: the comparison is >=, so the bit commits on the next cycle.
- cnt never wraps.
- SRC toggled mid-debounce: debouncers keep running; only the mux changes.
- wb_rst_i mid-transaction: ack is forced to 0 next edge, the pending access is dropped, and all registers return to reset values.

## Test plan
- Reset, then read all registers -> CTRL=0x1, SW_IN=0, DB_LIMIT=1000, STATUS=0. game_reset=1 during reset and 0 one cycle after release. Output pads oeb=0; all others oeb=1.
- DB_LIMIT=3; pad IN_BASE held at 1 from edge n -> game_in[0]=1 after edge n+5. A 3-cycle glitch -> game_in[0] unchanged.
- game_out=0xA5 -> io_out[OUT_BASE+:8]=0xA5 one cycle later. Write CTRL=0 -> io_out=0 and those oeb=1.
- Write CTRL=0x3 and SW_IN=0x9 -> game_in=0x9 regardless of pads. Read STATUS -> bits[19:16] still track the debounced pads.
- Write CTRL byte 0 with sel=4'b0010 -> CTRL unchanged. Access at BASE_ADDR+0x10 -> no ack for 8 cycles.
- Write SOFT_RST=1 -> game_reset=1 one cycle after ack. Assert wb_rst_i during a strobe -> no ack, and CTRL reads back 0x1 afterwards.
